// File: rtl/quad_encoder_emulator_if.sv
// Quadrature encoder emulator signal bundle: motor command in, encoder view out.
// The slave side is the emulator; the master side drives the motor command.
interface quad_encoder_emulator_if #(
    parameter int WINDOW_LOG2 = 10,
    parameter int N_WIDTH     = 32
);
    logic [1:0]             QUAD_ENCODER_EMULATOR_DIR_InBus;
    logic                   QUAD_ENCODER_EMULATOR_PWM_In;
    logic                   QUAD_ENCODER_EMULATOR_ENCODERA_Out;
    logic                   QUAD_ENCODER_EMULATOR_ENCODERB_Out;
    logic                   QUAD_ENCODER_EMULATOR_STEP_Out;
    logic [N_WIDTH-1:0]     QUAD_ENCODER_EMULATOR_POSITION_OutBus;
    logic [WINDOW_LOG2:0]   QUAD_ENCODER_EMULATOR_DUTY_OutBus;

    modport slave (
        input  QUAD_ENCODER_EMULATOR_DIR_InBus,
        input  QUAD_ENCODER_EMULATOR_PWM_In,
        output QUAD_ENCODER_EMULATOR_ENCODERA_Out,
        output QUAD_ENCODER_EMULATOR_ENCODERB_Out,
        output QUAD_ENCODER_EMULATOR_STEP_Out,
        output QUAD_ENCODER_EMULATOR_POSITION_OutBus,
        output QUAD_ENCODER_EMULATOR_DUTY_OutBus
    );

    modport master (
        output QUAD_ENCODER_EMULATOR_DIR_InBus,
        output QUAD_ENCODER_EMULATOR_PWM_In,
        input  QUAD_ENCODER_EMULATOR_ENCODERA_Out,
        input  QUAD_ENCODER_EMULATOR_ENCODERB_Out,
        input  QUAD_ENCODER_EMULATOR_STEP_Out,
        input  QUAD_ENCODER_EMULATOR_POSITION_OutBus,
        input  QUAD_ENCODER_EMULATOR_DUTY_OutBus
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Emulates a quadrature encoder from a motor PWM/direction command:
// duty is measured per window and integrated into a phase accumulator.
module quad_encoder_emulator #(
    parameter int WINDOW_LOG2 = 10,
    parameter int GAIN        = 64,
    parameter int ACC_WIDTH   = 24,
    parameter int N_WIDTH     = 32
) (
    input  logic                    QUAD_ENCODER_EMULATOR_CLOCK,
    input  logic                    QUAD_ENCODER_EMULATOR_RESET_InHigh,
    quad_encoder_emulator_if.slave  io
);
    localparam int DW = WINDOW_LOG2 + 1;
    localparam int PW = DW + 32;
    localparam int IW = ACC_WIDTH + 1;
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b10,
        S2 = 2'b11,
        S3 = 2'b01
    } qstate_t;

    qstate_t                r_state;
    qstate_t                w_state_nxt;
    logic [WINDOW_LOG2-1:0] r_win;
    logic [DW-1:0]          r_high;
    logic [DW-1:0]          r_duty;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [N_WIDTH-1:0]     r_pos;
    logic                   r_step;

    logic                   w_clk;
    logic                   w_rst;
    logic                   w_fwd;
    logic                   w_rev;
    logic                   w_run;
    logic                   w_last;
    logic                   w_carry;
    logic [DW-1:0]          w_pwm_ext;
    logic [IW-1:0]          w_inc;
    logic [IW:0]            w_sum;

    assign w_clk = QUAD_ENCODER_EMULATOR_CLOCK;
    assign w_rst = QUAD_ENCODER_EMULATOR_RESET_InHigh;

    assign w_fwd = io.QUAD_ENCODER_EMULATOR_DIR_InBus == 2'b01;
    assign w_rev = io.QUAD_ENCODER_EMULATOR_DIR_InBus == 2'b10;
    assign w_run = w_fwd | w_rev;

    assign w_last    = r_win == WIN_LAST;
    assign w_pwm_ext = DW'(io.QUAD_ENCODER_EMULATOR_PWM_In);

    // Product is formed wide, then fitted to the accumulator adder width.
    assign w_inc = IW'(PW'(r_duty) * PW'(GAIN));
    assign w_sum = (IW + 1)'(r_acc) + (IW + 1)'(w_inc);

    // Any overflow past the accumulator range counts as a single step.
    assign w_carry = w_run && (w_sum[IW:ACC_WIDTH] != '0);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_win  <= '0;
            r_high <= '0;
            r_duty <= '0;
        end else begin
            r_win <= r_win + WINDOW_LOG2'(1);
            if (w_last) begin
                r_duty <= r_high + w_pwm_ext;
                r_high <= '0;
            end else begin
                r_high <= r_high + w_pwm_ext;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst || !w_run) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_step <= 1'b0;
            r_pos  <= '0;
        end else begin
            r_step <= w_carry;
            unique case (1'b1)
                w_carry && w_fwd: r_pos <= r_pos + N_WIDTH'(1);
                w_carry && w_rev: r_pos <= r_pos - N_WIDTH'(1);
                default:          ;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_carry) begin
            unique case (r_state)
                S0: w_state_nxt = w_fwd ? S1 : S3;
                S1: w_state_nxt = w_fwd ? S2 : S0;
                S2: w_state_nxt = w_fwd ? S3 : S1;
                S3: w_state_nxt = w_fwd ? S0 : S2;
                default: w_state_nxt = S0;
            endcase
        end
    end

    assign io.QUAD_ENCODER_EMULATOR_ENCODERA_Out    = r_state[1];
    assign io.QUAD_ENCODER_EMULATOR_ENCODERB_Out    = r_state[0];
    assign io.QUAD_ENCODER_EMULATOR_STEP_Out        = r_step;
    assign io.QUAD_ENCODER_EMULATOR_POSITION_OutBus = r_pos;
    assign io.QUAD_ENCODER_EMULATOR_DUTY_OutBus     = r_duty;
endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench: a window/phase model predicts every cycle's outputs,
// a monitor compares them against the emulator just after each clock edge.
module tb_quad_encoder_emulator;
    localparam int WL  = 4;
    localparam int GN  = 4;
    localparam int AW  = 8;
    localparam int NW  = 32;
    localparam int WIN = 1 << WL;

    typedef struct packed {
        logic          a;
        logic          b;
        logic          stp;
        logic [NW-1:0] pos;
        logic [WL:0]   duty;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_encoder_emulator_if #(.WINDOW_LOG2(WL), .N_WIDTH(NW)) bus ();

    quad_encoder_emulator #(
        .WINDOW_LOG2(WL),
        .GAIN(GN),
        .ACC_WIDTH(AW),
        .N_WIDTH(NW)
    ) dut (
        .QUAD_ENCODER_EMULATOR_CLOCK(clk),
        .QUAD_ENCODER_EMULATOR_RESET_InHigh(rst),
        .io(bus)
    );

    snap_t         exp_q[$];
    int            n_chk  = 0;
    int            n_pass = 0;

    int            win_q[$];
    int            m_duty  = 0;
    int            m_acc   = 0;
    int            m_phase = 0;
    logic [NW-1:0] m_pos   = '0;
    bit            m_step  = 1'b0;
    bit            do_frc  = 1'b0;
    logic [1:0]    ab_tab[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    // Apply one clock of stimulus and predict the outputs after its edge.
    task automatic cyc(input bit r, input logic [1:0] d, input bit p);
        int    inc;
        int    sum;
        bit    fw;
        bit    rv;
        logic [1:0] ab;
        snap_t e;
        @(negedge clk);
        rst = r;
        bus.QUAD_ENCODER_EMULATOR_DIR_InBus = d;
        bus.QUAD_ENCODER_EMULATOR_PWM_In    = p;
        if (do_frc) begin
            #1;
            force dut.r_pos = 32'h7FFF_FFFF;
            #1;
            release dut.r_pos;
            m_pos = 32'h7FFF_FFFF;
        end
        if (r) begin
            win_q.delete();
            m_duty  = 0;
            m_acc   = 0;
            m_phase = 0;
            m_pos   = '0;
            m_step  = 1'b0;
        end else begin
            fw     = (d == 2'b01);
            rv     = (d == 2'b10);
            inc    = (m_duty * GN) % (1 << (AW + 1));
            m_step = 1'b0;
            if (fw || rv) begin
                sum    = m_acc + inc;
                m_step = (sum >= (1 << AW));
                m_acc  = sum % (1 << AW);
            end else begin
                m_acc = 0;
            end
            if (m_step) begin
                m_phase = (m_phase + (fw ? 1 : 3)) % 4;
                m_pos   = fw ? m_pos + 1 : m_pos - 1;
            end
            win_q.push_back(int'(p));
            if (win_q.size() == WIN) begin
                m_duty = win_q.sum();
                win_q.delete();
            end
        end
        ab     = ab_tab[m_phase];
        e.a    = ab[1];
        e.b    = ab[0];
        e.stp  = m_step;
        e.pos  = m_pos;
        e.duty = (WL + 1)'(m_duty);
        exp_q.push_back(e);
    endtask

    // Drive until the model predicts a step (optionally into a given phase).
    task automatic run_until_step(input logic [1:0] d, input int want, input int limit);
        int k;
        k = 0;
        do begin
            cyc(1'b0, d, 1'b1);
            k++;
        end while (!(m_step && (want < 0 || m_phase == want)) && k < limit);
        if (!(m_step && (want < 0 || m_phase == want))) begin
            n_chk++;
            $display("FAIL step_wait: no step after %0d clocks, required phase %0d", k, want);
        end
    endtask

    initial begin : monitor
        snap_t e;
        snap_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                g.a    = bus.QUAD_ENCODER_EMULATOR_ENCODERA_Out;
                g.b    = bus.QUAD_ENCODER_EMULATOR_ENCODERB_Out;
                g.stp  = bus.QUAD_ENCODER_EMULATOR_STEP_Out;
                g.pos  = bus.QUAD_ENCODER_EMULATOR_POSITION_OutBus;
                g.duty = bus.QUAD_ENCODER_EMULATOR_DUTY_OutBus;
                n_chk++;
                if (g === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t got ab=%b%b step=%b pos=%h duty=%0d, required ab=%b%b step=%b pos=%h duty=%0d",
                             $time, g.a, g.b, g.stp, g.pos, g.duty,
                             e.a, e.b, e.stp, e.pos, e.duty);
                end
            end
        end
    end

    initial begin : stim
        int dens;
        logic [1:0] rd;
        bus.QUAD_ENCODER_EMULATOR_DIR_InBus = 2'b01;
        bus.QUAD_ENCODER_EMULATOR_PWM_In    = 1'b1;

        // Full PWM forward from reset: first duty after 16 clocks, then steps.
        repeat (3) cyc(1'b1, 2'b01, 1'b1);
        repeat (40) cyc(1'b0, 2'b01, 1'b1);

        // Reverse right after stepping into S2.
        run_until_step(2'b01, 2, 64);
        repeat (20) cyc(1'b0, 2'b10, 1'b1);

        // Brake with residue, then resume forward.
        repeat (6) cyc(1'b0, 2'b01, 1'b1);
        repeat (7) cyc(1'b0, 2'b00, 1'b1);
        repeat (12) cyc(1'b0, 2'b01, 1'b1);

        // Position wrap from the largest positive value.
        do_frc = 1'b1;
        cyc(1'b0, 2'b00, 1'b1);
        do_frc = 1'b0;
        run_until_step(2'b01, -1, 64);
        repeat (3) cyc(1'b0, 2'b01, 1'b1);

        // Half duty in reverse.
        repeat (2) cyc(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 64; i++) cyc(1'b0, 2'b10, 1'(i % 2));

        // Reset mid-window after ten high samples.
        cyc(1'b1, 2'b01, 1'b1);
        repeat (10) cyc(1'b0, 2'b01, 1'b1);
        cyc(1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 48; i++) cyc(1'b0, 2'b01, 1'((i % 4) != 0));

        // Random mix of direction, duty density and occasional resets.
        dens = 50;
        rd   = 2'b01;
        for (int i = 0; i < 2000; i++) begin
            if (i % WIN == 0) dens = $urandom_range(0, 100);
            if ($urandom_range(0, 39) == 0) rd = 2'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 399) == 0), rd,
                1'($urandom_range(0, 99) < dens));
        end

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
